// File: rtl/adder_tree_sched.sv
`default_nettype none
// ============================================================================
// Module   : adder_tree_sched
// Purpose  : Two-requester round-robin job scheduler feeding an external
//            pipelined adder tree; accumulates tree sums into one result
//            per job. Optional macro SCHED_OVF_DET_EN adds res_ovf.
// Revision : 1.0 - initial release
// ============================================================================
module adder_tree_sched #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_INPUTS = 128,
    parameter int TREE_LAT   = 3,
    parameter int MAX_CHUNKS = 64,
    parameter int CW         = $clog2(MAX_CHUNKS + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req0_valid,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] req0_data,
    input  logic                             req0_last,
    output logic                             req0_ready,
    input  logic                             req1_valid,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] req1_data,
    input  logic                             req1_last,
    output logic                             req1_ready,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] tree_data,
    input  logic [31:0]                      tree_sum,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [31:0]                      res_sum,
    output logic                             res_id,
    output logic [CW-1:0]                    res_count,
`ifdef SCHED_OVF_DET_EN
    output logic                             res_ovf,
`endif
    output logic                             busy
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    logic [0:0]       r_state, w_state_nxt;
    logic             r_rr, w_rr_nxt;
    logic             r_gid, w_gid_nxt;
    logic             w_grant;
    logic             r_first_pend;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_cnt_inc;
    logic [31:0]      r_acc;
    logic [31:0]      w_acc_sum;
    logic [31:0]      w_acc_nxt;

    // Tag pipe: stage 0 travels alongside tree_data, stage TREE_LAT with tree_sum
    logic [TREE_LAT:0] r_pv, r_pfirst, r_plast, r_pid;

    logic                             w_sel_valid;
    logic                             w_sel_last;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] w_sel_data;
    logic                             w_accept;
    logic                             w_acc_last;
    logic                             w_grant_ok;

    assign w_sel_valid = r_gid ? req1_valid : req0_valid;
    assign w_sel_last  = r_gid ? req1_last  : req0_last;
    assign w_sel_data  = r_gid ? req1_data  : req0_data;
    assign w_accept    = (r_state == S_STREAM) && w_sel_valid;
    assign w_cnt_inc   = r_count + 1'b1;
    assign w_acc_last  = w_sel_last || (w_cnt_inc == CW'(MAX_CHUNKS));

    // Holding off grants until the previous result drains keeps at most one result in flight
    assign w_grant_ok  = !(res_valid && !res_ready) && !(|(r_pv & r_plast));

    assign req0_ready  = (r_state == S_STREAM) && !r_gid;
    assign req1_ready  = (r_state == S_STREAM) &&  r_gid;
    assign busy        = (r_state != S_IDLE) || (|r_pv);

    assign w_acc_sum   = r_acc + tree_sum;
    assign w_acc_nxt   = r_pfirst[TREE_LAT] ? tree_sum : w_acc_sum;

`ifdef SCHED_OVF_DET_EN
    logic r_ovf;
    logic w_step_ovf;
    logic w_ovf_nxt;
    assign w_step_ovf = (r_acc[31] == tree_sum[31]) && (w_acc_sum[31] != r_acc[31]);
    assign w_ovf_nxt  = r_pfirst[TREE_LAT] ? 1'b0 : (r_ovf || w_step_ovf);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        w_gid_nxt   = r_gid;
        w_grant     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_ok && (req0_valid || req1_valid)) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_STREAM;
                    if (req0_valid && req1_valid) begin
                        w_gid_nxt = r_rr;
                        w_rr_nxt  = ~r_rr;
                    end else begin
                        w_gid_nxt = req1_valid;
                    end
                end
            end
            S_STREAM: begin
                if (w_accept && w_acc_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rr         <= 1'b0;
            r_gid        <= 1'b0;
            r_first_pend <= 1'b0;
            r_count      <= '0;
            r_acc        <= '0;
            r_pv         <= '0;
            r_pfirst     <= '0;
            r_plast      <= '0;
            r_pid        <= '0;
            tree_data    <= '0;
            res_valid    <= 1'b0;
            res_sum      <= '0;
            res_id       <= 1'b0;
            res_count    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rr    <= w_rr_nxt;
            r_gid   <= w_gid_nxt;

            if (w_grant) begin
                r_first_pend <= 1'b1;
                r_count      <= '0;
            end else if (w_accept) begin
                r_first_pend <= 1'b0;
                r_count      <= w_cnt_inc;
            end

            if (w_accept) begin
                tree_data <= w_sel_data;
            end

            r_pv     <= {r_pv[TREE_LAT-1:0],     w_accept};
            r_pfirst <= {r_pfirst[TREE_LAT-1:0], w_accept && r_first_pend};
            r_plast  <= {r_plast[TREE_LAT-1:0],  w_accept && w_acc_last};
            r_pid    <= {r_pid[TREE_LAT-1:0],    w_accept && r_gid};

            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end

            if (r_pv[TREE_LAT]) begin
                r_acc <= w_acc_nxt;
                if (r_plast[TREE_LAT]) begin
                    res_valid <= 1'b1;
                    res_sum   <= w_acc_nxt;
                    res_id    <= r_pid[TREE_LAT];
                    res_count <= r_count;
                end
            end
        end
    end

`ifdef SCHED_OVF_DET_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf   <= 1'b0;
            res_ovf <= 1'b0;
        end else if (r_pv[TREE_LAT]) begin
            r_ovf <= w_ovf_nxt;
            if (r_plast[TREE_LAT]) begin
                res_ovf <= w_ovf_nxt;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_tree_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_tree_sched
// Purpose  : Scoreboard bench for adder_tree_sched with a behavioural adder
//            tree stub and per-requester expected-result queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_tree_sched;

    localparam int DW  = 16;
    localparam int NI  = 128;
    localparam int TL  = 3;
    localparam int MC  = 4;
    localparam int CW  = $clog2(MC + 1);
    localparam int BW  = NI * DW;
    localparam int TMO = 2000;

    typedef logic [BW-1:0] chunk_q_t[$];
    typedef struct packed {
        logic [31:0]   sum;
        logic [CW-1:0] cnt;
        logic          ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req0_last = 1'b0;
    logic          req1_valid = 1'b0, req1_last = 1'b0;
    logic [BW-1:0] req0_data = '0, req1_data = '0;
    logic          req0_ready, req1_ready;
    logic [BW-1:0] tree_data;
    logic [31:0]   tree_sum = '0;
    logic          res_valid, res_id, busy;
    logic          res_ready = 1'b0;
    logic [31:0]   res_sum;
    logic [CW-1:0] res_count;
`ifdef SCHED_OVF_DET_EN
    logic          res_ovf;
`endif

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q0[$];
    exp_t exp_q1[$];
    logic ord_q[$];
    logic force_max = 1'b0;
    bit   d0 = 0, d1 = 0;

    always #5 clk = ~clk;

    adder_tree_sched #(
        .DATA_WIDTH(DW), .NUM_INPUTS(NI), .TREE_LAT(TL), .MAX_CHUNKS(MC)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
        .tree_data(tree_data), .tree_sum(tree_sum),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
        .res_id(res_id), .res_count(res_count),
`ifdef SCHED_OVF_DET_EN
        .res_ovf(res_ovf),
`endif
        .busy(busy)
    );

    function automatic logic [31:0] chunk_sum(input logic [BW-1:0] c);
        logic [31:0]          s;
        logic signed [DW-1:0] e;
        s = '0;
        for (int i = 0; i < NI; i++) begin
            e = c[i*DW +: DW];
            s = s + {{(32-DW){e[DW-1]}}, e};
        end
        return s;
    endfunction

    // Behavioural adder tree: three register stages, no reset
    logic [31:0] t1 = '0, t2 = '0;
    always @(posedge clk) begin
        t1       <= force_max ? 32'h7FFF_FFFF : chunk_sum(tree_data);
        t2       <= t1;
        tree_sum <= t2;
    end

    function automatic logic [BW-1:0] fill(input int v);
        logic [BW-1:0] c;
        for (int i = 0; i < NI; i++) c[i*DW +: DW] = DW'(v);
        return c;
    endfunction

    function automatic chunk_q_t rand_job();
        chunk_q_t      q;
        logic [BW-1:0] c;
        int            n;
        n = $urandom_range(6, 1);
        for (int j = 0; j < n; j++) begin
            for (int i = 0; i < NI; i++) c[i*DW +: DW] = DW'($urandom);
            q.push_back(c);
        end
        return q;
    endfunction

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit id, input logic v, input logic [BW-1:0] d, input logic l);
        if (id) begin
            req1_valid = v; req1_data = d; req1_last = l;
        end else begin
            req0_valid = v; req0_data = d; req0_last = l;
        end
    endtask

    function automatic logic rdy(input bit id);
        return id ? req1_ready : req0_ready;
    endfunction

    task automatic push_chunk(input bit id, input logic [BW-1:0] d, input logic l);
        bit ok;
        ok = 0;
        drive(id, 1'b1, d, l);
        for (int k = 0; k < TMO && !ok; k++) begin
            @(negedge clk);
            ok = rdy(id);
        end
        check_eq(id ? "req1_accept" : "req0_accept", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        drive(id, 1'b0, d, 1'b0);
    endtask

    // Expected results: job chunks split every MC chunks, sums in 32-bit wrap
    task automatic send_job(input bit id, input chunk_q_t ch, input int gmin, input int gmax);
        logic [31:0] acc, s;
        longint      w;
        int          cnt, g;
        bit          ovf;
        exp_t        e;
        acc = '0; cnt = 0; ovf = 0;
        foreach (ch[i]) begin
            s = force_max ? 32'h7FFF_FFFF : chunk_sum(ch[i]);
            if (cnt == 0) begin
                acc = s;
                ovf = 0;
            end else begin
                w   = longint'($signed(acc)) + longint'($signed(s));
                ovf = ovf || (w > 64'sd2147483647) || (w < -64'sd2147483648);
                acc = w[31:0];
            end
            cnt++;
            if (cnt == MC || i == ch.size() - 1) begin
                e.sum = acc; e.cnt = CW'(cnt); e.ovf = ovf;
                if (id) exp_q1.push_back(e); else exp_q0.push_back(e);
                cnt = 0;
            end
        end
        foreach (ch[i]) begin
            if (i > 0) begin
                g = $urandom_range(gmax, gmin);
                if (g > 0) begin
                    repeat (g) @(posedge clk);
                    #1;
                end
            end
            push_chunk(id, ch[i], i == ch.size() - 1);
        end
    endtask

    task automatic monitor();
        logic          hold, hi;
        logic [31:0]   hs;
        logic [CW-1:0] hc;
        exp_t          e;
        bit            empty;
        hold = 0; hi = 0; hs = '0; hc = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 0;
                continue;
            end
            if (hold) begin
                check_eq("hold_valid", 64'(res_valid), 64'd1);
                check_eq("hold_sum",   64'(res_sum),   64'(hs));
                check_eq("hold_id",    64'(res_id),    64'(hi));
                check_eq("hold_count", 64'(res_count), 64'(hc));
            end
            if (res_valid && res_ready) begin
                ord_q.push_back(res_id);
                empty = res_id ? (exp_q1.size() == 0) : (exp_q0.size() == 0);
                check_eq("res_expected", 64'(empty), 64'd0);
                if (!empty) begin
                    e = res_id ? exp_q1.pop_front() : exp_q0.pop_front();
                    check_eq(res_id ? "res_sum_id1" : "res_sum_id0", 64'(res_sum), 64'(e.sum));
                    check_eq("res_count", 64'(res_count), 64'(e.cnt));
`ifdef SCHED_OVF_DET_EN
                    check_eq("res_ovf", 64'(res_ovf), 64'(e.ovf));
`endif
                end
            end
            hold = res_valid && !res_ready;
            hs = res_sum; hi = res_id; hc = res_count;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || busy || res_valid) && k < TMO) begin
            @(negedge clk);
            k++;
        end
        check_eq("drain_pending", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

    initial begin
        chunk_q_t q0, q1;
        int       exp_ord[4];
        int       k;
        exp_ord[0] = 0; exp_ord[1] = 1; exp_ord[2] = 0; exp_ord[3] = 1;

        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_tree_data_zero", 64'(tree_data == '0), 64'd1);
        check_eq("rst_res_valid", 64'(res_valid), 64'd0);
        check_eq("rst_res_sum",   64'(res_sum),   64'd0);
        check_eq("rst_res_count", 64'(res_count), 64'd0);
        check_eq("rst_ready0",    64'(req0_ready), 64'd0);
        check_eq("rst_ready1",    64'(req1_ready), 64'd0);
        check_eq("rst_busy",      64'(busy),       64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        res_ready = 1'b1;

        // Contention from reset: round-robin alternates 0,1,0,1
        q0.delete(); q0.push_back(fill(3));
        q1.delete(); q1.push_back(fill(5));
        ord_q.delete();
        fork
            begin send_job(0, q0, 0, 0); send_job(0, q0, 0, 0); end
            begin send_job(1, q1, 0, 0); send_job(1, q1, 0, 0); end
        join
        drain();
        check_eq("rr_order_len", 64'(ord_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < ord_q.size(); i++)
            check_eq("rr_order", 64'(ord_q[i]), 64'(exp_ord[i]));

        // Two-chunk job: +1 then -2 -> -128
        q0.delete(); q0.push_back(fill(1)); q0.push_back(fill(-2));
        send_job(0, q0, 0, 0);
        drain();

        // Bubbles between chunks on requester 1
        q1.delete(); q1.push_back(fill(1)); q1.push_back(fill(2)); q1.push_back(fill(3));
        send_job(1, q1, 2, 2);
        drain();

        // Backpressure: result held, pending req0 job not accepted
        res_ready = 1'b0;
        q0.delete(); q0.push_back(fill(7));
        q1.delete(); q1.push_back(fill(9));
        fork
            begin send_job(0, q0, 0, 0); send_job(0, q1, 0, 0); end
            begin
                k = 0;
                while (!res_valid && k < TMO) begin
                    @(negedge clk);
                    k++;
                end
                check_eq("bp_result_seen", 64'(res_valid), 64'd1);
                repeat (10) begin
                    @(negedge clk);
                    check_eq("bp_req0_ready", 64'(req0_ready), 64'd0);
                end
                @(posedge clk);
                #1;
                res_ready = 1'b1;
            end
        join
        drain();

        // Chunk limit: 6 chunks split into 4 + 2
        q0.delete();
        for (int i = 0; i < 6; i++) q0.push_back(fill(1));
        send_job(0, q0, 0, 0);
        drain();

        // Reset mid-job discards the in-flight chunk
        push_chunk(0, fill(1), 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_rst_tree_data_zero", 64'(tree_data == '0), 64'd1);
        check_eq("mid_rst_res_valid", 64'(res_valid), 64'd0);
        check_eq("mid_rst_ready0",    64'(req0_ready), 64'd0);
        check_eq("mid_rst_busy",      64'(busy),       64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("post_rst_no_result", 64'(res_valid), 64'd0);
        @(posedge clk);
        #1;
        q0.delete(); q0.push_back(fill(1));
        send_job(0, q0, 0, 0);
        drain();

        // Randomized traffic with random bubbles and backpressure
        fork
            begin for (int j = 0; j < 20; j++) send_job(0, rand_job(), 0, 3); d0 = 1; end
            begin for (int j = 0; j < 20; j++) send_job(1, rand_job(), 0, 3); d1 = 1; end
            begin
                while (!(d0 && d1)) begin
                    @(posedge clk);
                    #1;
                    res_ready = ($urandom_range(3, 0) != 0);
                end
                res_ready = 1'b1;
            end
        join
        drain();

`ifdef SCHED_OVF_DET_EN
        // Saturated tree output: one chunk no overflow, two chunks overflow
        force_max = 1'b1;
        q0.delete(); q0.push_back(fill(0));
        send_job(0, q0, 0, 0);
        drain();
        q0.push_back(fill(0));
        send_job(0, q0, 0, 0);
        drain();
        force_max = 1'b0;
        repeat (5) @(posedge clk);
        #1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
